// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the dual-PE instruction-fetch arbiter.
package imem_arb_pkg;

  localparam int unsigned PE_CNT     = 2;
  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned IMEM_IDX_W = $clog2(IMEM_DEPTH);
  localparam int unsigned INSN_W     = 32;

  typedef logic pe_id_t;

  localparam pe_id_t PE0 = 1'b0;
  localparam pe_id_t PE1 = 1'b1;

  typedef struct packed {
    logic [INSN_W-1:0] data;
    logic              err;
  } fetch_resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer names the PE that wins a tie
// and hands priority to the other PE after every grant.
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  pe_id_t ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= PE0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    if (&req_i) begin
      gnt_o = (ptr_q == PE1) ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = PE1;
    end else if (gnt_o[1]) begin
      ptr_d = PE0;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one synchronous instruction-memory read port between two PE fetch units,
// returning each word through a per-PE one-entry response buffer.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = INSN_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [ADDR_W-1:0]        req_addr0,
  input  logic [ADDR_W-1:0]        req_addr1,
  output logic [1:0]               req_ready,
  output logic [1:0]               resp_valid,
  output logic [DATA_W-1:0]        resp_data0,
  output logic [DATA_W-1:0]        resp_data1,
  output logic [1:0]               resp_err,
  input  logic [1:0]               resp_ready,
  output logic                     mem_en,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned     IDX_W       = $clog2(DEPTH);
  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);

  logic [1:0]        resp_v_q, resp_v_d;
  logic [1:0]        resp_e_q, resp_e_d;
  logic [DATA_W-1:0] resp_dat_q [2];
  logic [DATA_W-1:0] resp_dat_d [2];

  logic   inflight_v_q, inflight_v_d;
  pe_id_t inflight_id_q, inflight_id_d;
  logic   inflight_err_q, inflight_err_d;

  logic [1:0]        eligible;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_fault;

  // A PE competes only with no fetch in flight and room in its buffer by next edge.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < PE_CNT; i++) begin
      eligible[i] = rst & req_valid[i]
                  & !(inflight_v_q & (inflight_id_q == pe_id_t'(i)))
                  & (!resp_v_q[i] | resp_ready[i]);
    end
  end

  rr_arbiter2 u_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  (eligible),
    .gnt_o  (gnt)
  );

  always_comb begin
    gnt_addr  = gnt[1] ? req_addr1 : req_addr0;
    gnt_fault = (gnt_addr[1:0] != 2'b00) || (gnt_addr[ADDR_W-1:2] >= DEPTH_WORDS);
    req_ready = gnt;
    mem_en    = (|gnt) & !gnt_fault;
    mem_addr  = mem_en ? gnt_addr[2 +: IDX_W] : '0;
  end

  always_comb begin
    inflight_v_d   = |gnt;
    inflight_id_d  = gnt[1] ? PE1 : PE0;
    inflight_err_d = (|gnt) & gnt_fault;
  end

  // Writeback takes precedence over a pop so a same-cycle pop+fill keeps the new word.
  always_comb begin
    resp_v_d   = resp_v_q;
    resp_e_d   = resp_e_q;
    resp_dat_d = resp_dat_q;
    for (int unsigned i = 0; i < PE_CNT; i++) begin
      if (inflight_v_q && (inflight_id_q == pe_id_t'(i))) begin
        resp_v_d[i]   = 1'b1;
        resp_e_d[i]   = inflight_err_q;
        resp_dat_d[i] = inflight_err_q ? '0 : mem_rdata;
      end else if (resp_v_q[i] && resp_ready[i]) begin
        resp_v_d[i]   = 1'b0;
        resp_e_d[i]   = 1'b0;
        resp_dat_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_v_q   <= 1'b0;
      inflight_id_q  <= PE0;
      inflight_err_q <= 1'b0;
      resp_v_q       <= '0;
      resp_e_q       <= '0;
      resp_dat_q     <= '{default: '0};
    end else begin
      inflight_v_q   <= inflight_v_d;
      inflight_id_q  <= inflight_id_d;
      inflight_err_q <= inflight_err_d;
      resp_v_q       <= resp_v_d;
      resp_e_q       <= resp_e_d;
      resp_dat_q     <= resp_dat_d;
    end
  end

  assign resp_valid = resp_v_q;
  assign resp_err   = resp_e_q;
  assign resp_data0 = resp_dat_q[0];
  assign resp_data1 = resp_dat_q[1];

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a synchronous memory model
// returning 0xA0000000 | word_index one cycle after mem_en.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data0, resp_data1;
  logic [1:0]  resp_err;
  logic [1:0]  resp_ready;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= 32'hA000_0000 | {22'h0, mem_addr};
  end

  imem_fetch_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data0 (resp_data0),
    .resp_data1 (resp_data1),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02b expected %02b", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 2'b11;
    req_addr0  = 32'h0;
    req_addr1  = 32'h0;
    resp_ready = 2'b00;
    #2;
    chk2 ("rst_req_ready",  req_ready,  2'b00);
    chk1 ("rst_mem_en",     mem_en,     1'b0);
    chk2 ("rst_resp_valid", resp_valid, 2'b00);
    chk2 ("rst_resp_err",   resp_err,   2'b00);
    chk32("rst_data0",      resp_data0, 32'h0);
    chk32("rst_data1",      resp_data1, 32'h0);
    #10;
    rst       = 1'b1;
    req_valid = 2'b00;

    // single PE0 fetch of byte 0x10 -> word 4
    cyc(); req_valid = 2'b01; req_addr0 = 32'h10; resp_ready = 2'b11; #1;
    chk2 ("s_ready",   req_ready, 2'b01);
    chk1 ("s_mem_en",  mem_en,    1'b1);
    chk10("s_mem_addr", mem_addr, 10'd4);
    cyc(); req_valid = 2'b00; #1;
    chk2 ("s_wait_valid", resp_valid, 2'b00);
    cyc(); #1;
    chk2 ("s_resp_valid", resp_valid, 2'b01);
    chk32("s_resp_data0", resp_data0, 32'hA000_0004);
    chk2 ("s_resp_err",   resp_err,   2'b00);
    cyc(); #1;
    chk2 ("s_pop_valid", resp_valid, 2'b00);
    chk32("s_pop_data0", resp_data0, 32'h0);

    // pointer now favours PE1; reset must return it to PE0
    #1; rst = 1'b0; #1;
    chk1("rst2_mem_en", mem_en, 1'b0);
    #1; rst = 1'b1;

    // contention: alternate PE0/PE1
    cyc(); req_valid = 2'b11; req_addr0 = 32'h0; req_addr1 = 32'h100; #1;
    chk2 ("c0_ready", req_ready, 2'b01);
    chk1 ("c0_mem_en", mem_en, 1'b1);
    chk10("c0_mem_addr", mem_addr, 10'd0);
    cyc(); #1;
    chk2 ("c1_ready", req_ready, 2'b10);
    chk10("c1_mem_addr", mem_addr, 10'd64);
    chk2 ("c1_resp_valid", resp_valid, 2'b00);
    cyc(); #1;
    chk2 ("c2_ready", req_ready, 2'b01);
    chk10("c2_mem_addr", mem_addr, 10'd0);
    chk2 ("c2_resp_valid", resp_valid, 2'b01);
    chk32("c2_data0", resp_data0, 32'hA000_0000);
    cyc(); #1;
    chk2 ("c3_ready", req_ready, 2'b10);
    chk2 ("c3_resp_valid", resp_valid, 2'b10);
    chk32("c3_data1", resp_data1, 32'hA000_0040);
    chk32("c3_data0", resp_data0, 32'h0);
    cyc(); #1;
    chk2 ("c4_ready", req_ready, 2'b01);
    chk2 ("c4_resp_valid", resp_valid, 2'b01);
    cyc(); req_valid = 2'b00;
    cyc(); cyc(); #1;
    chk2 ("c_drain_valid", resp_valid, 2'b00);

    // backpressure on PE1
    cyc(); req_valid = 2'b10; req_addr1 = 32'h8; resp_ready = 2'b01; #1;
    chk2 ("b0_ready", req_ready, 2'b10);
    chk10("b0_mem_addr", mem_addr, 10'd2);
    cyc(); req_valid = 2'b11; req_addr0 = 32'h4; #1;
    chk2 ("b1_ready", req_ready, 2'b01);
    chk10("b1_mem_addr", mem_addr, 10'd1);
    cyc(); #1;
    chk2 ("b2_ready", req_ready, 2'b00);
    chk1 ("b2_mem_en", mem_en, 1'b0);
    chk2 ("b2_resp_valid", resp_valid, 2'b10);
    chk32("b2_data1", resp_data1, 32'hA000_0002);
    cyc(); #1;
    chk2 ("b3_ready", req_ready, 2'b01);
    chk2 ("b3_resp_valid", resp_valid, 2'b11);
    chk32("b3_data0", resp_data0, 32'hA000_0001);
    chk32("b3_data1", resp_data1, 32'hA000_0002);
    cyc(); #1;
    chk2 ("b4_ready", req_ready, 2'b00);
    chk2 ("b4_resp_valid", resp_valid, 2'b10);
    cyc(); #1;
    chk2 ("b5_ready", req_ready, 2'b01);
    chk32("b5_data1", resp_data1, 32'hA000_0002);
    cyc(); req_valid = 2'b00; resp_ready = 2'b11;
    cyc(); cyc(); #1;
    chk2 ("b_drain_valid", resp_valid, 2'b00);

    // faults: misaligned PE0, out-of-range PE1
    cyc(); req_valid = 2'b11; req_addr0 = 32'h2; req_addr1 = 32'h1000; #1;
    chk2 ("f0_ready", req_ready, 2'b10);
    chk1 ("f0_mem_en", mem_en, 1'b0);
    cyc(); #1;
    chk2 ("f1_ready", req_ready, 2'b01);
    chk1 ("f1_mem_en", mem_en, 1'b0);
    chk2 ("f1_resp_valid", resp_valid, 2'b00);
    cyc(); req_valid = 2'b00; #1;
    chk2 ("f2_resp_valid", resp_valid, 2'b10);
    chk2 ("f2_resp_err", resp_err, 2'b10);
    chk32("f2_data1", resp_data1, 32'h0);
    cyc(); #1;
    chk2 ("f3_resp_valid", resp_valid, 2'b01);
    chk2 ("f3_resp_err", resp_err, 2'b01);
    chk32("f3_data0", resp_data0, 32'h0);
    cyc(); #1;
    chk2 ("f4_resp_valid", resp_valid, 2'b00);
    chk2 ("f4_resp_err", resp_err, 2'b00);

    // PE0 streaming alone
    cyc(); req_valid = 2'b01; req_addr0 = 32'h20; resp_ready = 2'b01; #1;
    chk2 ("p0_ready", req_ready, 2'b01);
    chk10("p0_mem_addr", mem_addr, 10'd8);
    cyc(); #1;
    chk2 ("p1_ready", req_ready, 2'b00);
    cyc(); req_addr0 = 32'h24; #1;
    chk2 ("p2_resp_valid", resp_valid, 2'b01);
    chk32("p2_data0", resp_data0, 32'hA000_0008);
    chk2 ("p2_ready", req_ready, 2'b01);
    chk10("p2_mem_addr", mem_addr, 10'd9);
    cyc(); req_valid = 2'b00; #1;
    chk2 ("p3_resp_valid", resp_valid, 2'b00);
    cyc(); #1;
    chk2 ("p4_resp_valid", resp_valid, 2'b01);
    chk32("p4_data0", resp_data0, 32'hA000_0009);
    cyc();

    // reset while a PE1 fetch is in flight
    cyc(); req_valid = 2'b10; req_addr1 = 32'h8; resp_ready = 2'b11; #1;
    chk2 ("x0_ready", req_ready, 2'b10);
    cyc(); #1; rst = 1'b0; #1;
    chk2 ("x1_resp_valid", resp_valid, 2'b00);
    chk1 ("x1_mem_en", mem_en, 1'b0);
    chk2 ("x1_ready", req_ready, 2'b00);
    #1; rst = 1'b1; req_valid = 2'b00;
    cyc(); #1;
    chk2 ("x2_resp_valid", resp_valid, 2'b00);
    chk1 ("x2_mem_en", mem_en, 1'b0);
    cyc(); req_valid = 2'b11; req_addr0 = 32'h0; req_addr1 = 32'h100; #1;
    chk2 ("x3_ready", req_ready, 2'b01);
    chk2 ("x3_resp_valid", resp_valid, 2'b00);
    cyc(); req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
